elevator_scan_ctrl: RTL and testbench

//   Parametrised elevator controller for FLOORS floors, driven by divided clock clk_out.

---
 rtl/elevator_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
// Elevator controller: latches cabin/landing calls into a pending queue and
// serves them with a SCAN sweep plus a timed door dwell.
// Ports:
//   clk_out   - divided system clock, rising edge
//   RST       - asynchronous active-low reset
//   in_call   - cabin buttons, one bit per floor
//   out_call  - landing buttons, one bit per floor
//   loc       - floor sensors, one-hot when level with a floor, else 0
//   motor     - 00 idle, 10 up, 11 down
//   door      - one-hot open door, 0 = all closed
//   queue     - pending requests
//   direction - sweep direction, 1 up / 0 down
//   fault     - sticky sensor fault (multiple loc bits set)
module elevator_scan_ctrl #(
  parameter int unsigned FLOORS      = 4,
  parameter int unsigned DOOR_CYCLES = 3
) (
  input  logic              clk_out,
  input  logic              RST,
  input  logic [FLOORS-1:0] in_call,
  input  logic [FLOORS-1:0] out_call,
  input  logic [FLOORS-1:0] loc,
  output logic [1:0]        motor,
  output logic [FLOORS-1:0] door,
  output logic [FLOORS-1:0] queue,
  output logic              direction,
  output logic              fault
);

  localparam int unsigned   FW         = $clog2(FLOORS);
  localparam int unsigned   DW         = $clog2(DOOR_CYCLES + 1);
  localparam logic [FW-1:0] TOP_FLOOR  = FW'(FLOORS - 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DOOR_CYCLES);
  localparam logic [1:0]    MOTOR_OFF  = 2'b00;
  localparam logic [1:0]    MOTOR_UP   = 2'b10;
  localparam logic [1:0]    MOTOR_DOWN = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        motor_q, motor_d;
  logic [FLOORS-1:0] door_q, door_d;
  logic [FLOORS-1:0] queue_q, queue_d;
  logic              direction_q, direction_d;
  logic              fault_q, fault_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [FW-1:0]     cur_floor_q, cur_floor_d;

  logic [FLOORS-1:0] calls, req, here_mask;
  logic              loc_multi, loc_valid;
  logic [FW-1:0]     loc_idx, here;
  logic              ahead_up, ahead_dn;

  // Sensor decode and request scan. "here" follows loc whenever it is one-hot,
  // so the floor seen during reset needs no asynchronously loaded register.
  always_comb begin
    calls     = in_call | out_call;
    req       = queue_q | calls;
    loc_multi = (loc & (loc - FLOORS'(1))) != '0;
    loc_valid = (loc != '0) && !loc_multi;
    loc_idx   = '0;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (loc[i]) loc_idx = loc_idx | FW'(i);
    end
    here      = loc_valid ? loc_idx : cur_floor_q;
    here_mask = FLOORS'(1) << here;
    ahead_up  = 1'b0;
    ahead_dn  = 1'b0;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (req[i] && (FW'(i) > here)) ahead_up = 1'b1;
      if (req[i] && (FW'(i) < here)) ahead_dn = 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    motor_d     = motor_q;
    door_d      = door_q;
    direction_d = direction_q;
    fault_d     = fault_q;
    dwell_d     = dwell_q;
    cur_floor_d = here;
    // While the door is open, a call for that floor extends the dwell instead of queuing.
    queue_d     = (state_q == S_DOOR) ? (queue_q | (calls & ~door_q)) : req;

    unique case (state_q)
      S_IDLE: begin
        motor_d = MOTOR_OFF;
        door_d  = '0;
        if ((req & here_mask) != '0) begin
          state_d = S_DOOR;
          door_d  = here_mask;
          queue_d = req & ~here_mask;
          dwell_d = DWELL_LOAD;
        end else if ((direction_q && ahead_up) || (!direction_q && ahead_dn)) begin
          state_d = S_MOVE;
          motor_d = direction_q ? MOTOR_UP : MOTOR_DOWN;
        end else if (ahead_up || ahead_dn) begin
          state_d     = S_MOVE;
          direction_d = !direction_q;
          motor_d     = direction_q ? MOTOR_DOWN : MOTOR_UP;
        end
      end
      S_MOVE: begin
        door_d = '0;
        if (loc_valid && ((req & loc) != '0)) begin
          state_d = S_DOOR;
          motor_d = MOTOR_OFF;
          door_d  = loc;
          queue_d = req & ~loc;
          dwell_d = DWELL_LOAD;
        end else if (loc_valid && ((direction_q && (loc_idx == TOP_FLOOR)) ||
                                   (!direction_q && (loc_idx == '0)))) begin
          state_d = S_IDLE;
          motor_d = MOTOR_OFF;
        end
      end
      S_DOOR: begin
        motor_d = MOTOR_OFF;
        if ((calls & door_q) != '0) begin
          dwell_d = DWELL_LOAD;
        end else if (dwell_q <= DW'(1)) begin
          state_d = S_IDLE;
          door_d  = '0;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      default: begin
        motor_d = MOTOR_OFF;
        door_d  = '0;
        fault_d = 1'b1;
      end
    endcase

    // A multi-bit sensor reading overrides everything and is sticky.
    if (loc_multi) begin
      state_d = S_FAULT;
      motor_d = MOTOR_OFF;
      door_d  = '0;
      fault_d = 1'b1;
      queue_d = req;
    end
  end

  always_ff @(posedge clk_out or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      motor_q     <= MOTOR_OFF;
      door_q      <= '0;
      queue_q     <= '0;
      direction_q <= 1'b1;
      fault_q     <= 1'b0;
      dwell_q     <= '0;
      cur_floor_q <= '0;
    end else begin
      state_q     <= state_d;
      motor_q     <= motor_d;
      door_q      <= door_d;
      queue_q     <= queue_d;
      direction_q <= direction_d;
      fault_q     <= fault_d;
      dwell_q     <= dwell_d;
      cur_floor_q <= cur_floor_d;
    end
  end

  assign motor     = motor_q;
  assign door      = door_q;
  assign queue     = queue_q;
  assign direction = direction_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl (FLOORS=4, DOOR_CYCLES=3).
module tb_elevator_scan_ctrl;

  logic       clk_out;
  logic       RST;
  logic [3:0] in_call;
  logic [3:0] out_call;
  logic [3:0] loc;
  logic [1:0] motor;
  logic [3:0] door;
  logic [3:0] queue;
  logic       direction;
  logic       fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] ic;
    logic [3:0] oc;
    logic [3:0] lc;
    logic [1:0] m;
    logic [3:0] d;
    logic [3:0] q;
    logic       dr;
    logic       f;
  } vec_t;

  vec_t vecs[$];

  elevator_scan_ctrl #(.FLOORS(4), .DOOR_CYCLES(3)) dut (
    .clk_out  (clk_out),
    .RST      (RST),
    .in_call  (in_call),
    .out_call (out_call),
    .loc      (loc),
    .motor    (motor),
    .door     (door),
    .queue    (queue),
    .direction(direction),
    .fault    (fault)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  task automatic add(input logic [3:0] ic, input logic [3:0] oc, input logic [3:0] lc,
                     input logic [1:0] m, input logic [3:0] d, input logic [3:0] q,
                     input logic dr, input logic f);
    vec_t v;
    v.ic = ic; v.oc = oc; v.lc = lc; v.m = m; v.d = d; v.q = q; v.dr = dr; v.f = f;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [3:0] ic, input logic [3:0] oc, input logic [3:0] lc);
    @(negedge clk_out);
    in_call  = ic;
    out_call = oc;
    loc      = lc;
    @(posedge clk_out);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] m, input logic [3:0] d,
                       input logic [3:0] q, input logic dr, input logic f);
    checks++;
    if ({motor, door, queue, direction, fault} !== {m, d, q, dr, f}) begin
      errors++;
      $display("FAIL %s: got motor=%b door=%b queue=%b dir=%b fault=%b, expected motor=%b door=%b queue=%b dir=%b fault=%b",
               name, motor, door, queue, direction, fault, m, d, q, dr, f);
    end
  endtask

  initial begin
    // ic, oc, loc -> motor, door, queue, dir, fault
    // Basic trip 0 -> 2 with 3-edge door dwell
    add(4'b0100, 4'b0000, 4'b0001, 2'b10, 4'b0000, 4'b0100, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0001, 2'b10, 4'b0000, 4'b0100, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 4'b0100, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b10, 4'b0000, 4'b0100, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 4'b0100, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0100, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0100, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0100, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);
    // Continue up to floor 3
    add(4'b0000, 4'b1000, 4'b0100, 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'b00, 4'b1000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'b00, 4'b1000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'b00, 4'b1000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);
    // At floor 3 with requests only behind: flip, serve 2, skip 1, serve 0
    add(4'b0001, 4'b0100, 4'b1000, 2'b11, 4'b0000, 4'b0101, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'b11, 4'b0000, 4'b0101, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'b11, 4'b0000, 4'b0101, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0100, 4'b0001, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0100, 4'b0001, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0100, 4'b0001, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0000, 4'b0001, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b11, 4'b0000, 4'b0001, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'b11, 4'b0000, 4'b0001, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b11, 4'b0000, 4'b0001, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'b11, 4'b0000, 4'b0001, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0001, 2'b00, 4'b0001, 4'b0000, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0001, 2'b00, 4'b0001, 4'b0000, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0001, 2'b00, 4'b0001, 4'b0000, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0001, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    // Sweep up to 3; landing call at 1 raised between floors is served first
    add(4'b1000, 4'b0000, 4'b0001, 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0001, 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0010, 4'b0000, 2'b10, 4'b0000, 4'b1010, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 4'b1010, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b00, 4'b0010, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b00, 4'b0010, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b00, 4'b0010, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b00, 4'b0000, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0100, 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'b00, 4'b1000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'b00, 4'b1000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'b00, 4'b1000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);
    // Terminal guard: sensor for floor 1 missed, cabin reaches 0 moving down
    add(4'b0010, 4'b0000, 4'b1000, 2'b11, 4'b0000, 4'b0010, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'b11, 4'b0000, 4'b0010, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0001, 2'b00, 4'b0000, 4'b0010, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0001, 2'b10, 4'b0000, 4'b0010, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b00, 4'b0010, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b00, 4'b0010, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b00, 4'b0010, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // Reset state with cabin at floor 0
    RST      = 1'b0;
    in_call  = 4'b0000;
    out_call = 4'b0000;
    loc      = 4'b0001;
    #12;
    check("reset_values", 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);
    @(negedge clk_out);
    RST = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].ic, vecs[i].oc, vecs[i].lc);
      check($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].q, vecs[i].dr, vecs[i].f);
    end

    // Door reopen: call for the open floor at dwell=1 restarts the dwell
    step(4'b0010, 4'b0000, 4'b0010);
    check("reopen_open", 2'b00, 4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0010);
    check("reopen_dw2", 2'b00, 4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0010);
    check("reopen_dw1", 2'b00, 4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0010, 4'b0000, 4'b0010);
    check("reopen_reload", 2'b00, 4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0010);
    check("reopen_more1", 2'b00, 4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0010);
    check("reopen_more2", 2'b00, 4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0010);
    check("reopen_close", 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // Sensor fault while moving is sticky, queue keeps latching
    step(4'b1000, 4'b0000, 4'b0010);
    check("fault_move", 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000);
    check("fault_between", 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0011);
    check("fault_enter", 2'b00, 4'b0000, 4'b1000, 1'b1, 1'b1);
    step(4'b0000, 4'b0001, 4'b0010);
    check("fault_latch", 2'b00, 4'b0000, 4'b1001, 1'b1, 1'b1);
    step(4'b0000, 4'b0000, 4'b1000);
    check("fault_sticky", 2'b00, 4'b0000, 4'b1001, 1'b1, 1'b1);
    @(negedge clk_out);
    RST = 1'b0;
    #1;
    check("fault_reset", 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a downward move
    @(negedge clk_out);
    RST = 1'b1;
    step(4'b0001, 4'b0000, 4'b1000);
    check("down_start", 2'b11, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000);
    check("down_move", 2'b11, 4'b0000, 4'b0001, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check("async_reset", 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
